// File: rtl/iommu_wsi_gateway.sv
// Level-to-pulse interrupt gateway behind the IOMMU wired-signal outputs.
// Each wire latches into a per-source pending bit; a round-robin arbiter offers one source at a time.

module iommu_wsi_gateway_src (
    input  logic clk_i,
    input  logic rst_i,
    input  logic wire_i,
    input  logic claim_i,
    input  logic complete_i,
    output logic pending_o,
    output logic in_service_o
);

    // pending and in_service are mutually exclusive: a source re-arms only once fully completed
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_o    <= 1'b0;
            in_service_o <= 1'b0;
        end else begin
            if (claim_i)
                pending_o <= 1'b0;
            else if (wire_i && !pending_o && !in_service_o)
                pending_o <= 1'b1;

            // completion sees pre-edge in_service, so a same-cycle claim wins
            if (claim_i)
                in_service_o <= 1'b1;
            else if (complete_i && in_service_o)
                in_service_o <= 1'b0;
        end
    end

endmodule

module iommu_wsi_gateway #(
    parameter int N_WIRES = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [N_WIRES-1:0]                 wsi_wires_i,
    input  logic [N_WIRES-1:0]                 enable_i,
    output logic                               irq_valid_o,
    output logic [$clog2(N_WIRES)-1:0]         irq_id_o,
    input  logic                               irq_ready_i,
    input  logic                               complete_valid_i,
    input  logic [$clog2(N_WIRES)-1:0]         complete_id_i,
    output logic [N_WIRES-1:0]                 pending_o,
    output logic [N_WIRES-1:0]                 in_service_o
);

    localparam int ID_W = $clog2(N_WIRES);

    typedef enum logic {S_IDLE, S_OFFER} state_t;

    typedef struct packed {
        logic            found;
        logic [ID_W-1:0] id;
    } grant_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     id_q;
    logic [ID_W-1:0]     rr_ptr;
    logic                handshake;
    logic [N_WIRES-1:0]  claim;
    logic [N_WIRES-1:0]  complete;
    logic [N_WIRES-1:0]  eligible;
    grant_t              grant;

    assign handshake = (state_q == S_OFFER) && irq_ready_i;
    assign eligible  = pending_o & enable_i;

    for (genvar i = 0; i < N_WIRES; i++) begin : g_src
        assign claim[i]    = handshake && (id_q == ID_W'(i));
        assign complete[i] = complete_valid_i && (complete_id_i == ID_W'(i));

        iommu_wsi_gateway_src u_src (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .wire_i       (wsi_wires_i[i]),
            .claim_i      (claim[i]),
            .complete_i   (complete[i]),
            .pending_o    (pending_o[i]),
            .in_service_o (in_service_o[i])
        );
    end

    // First eligible source at or above rr_ptr, wrapping; one extra bit holds the unwrapped sum
    always_comb begin
        logic [ID_W:0] idx;
        grant = '0;
        idx   = '0;
        for (int k = 0; k < N_WIRES; k++) begin
            idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(N_WIRES))
                idx = idx - (ID_W+1)'(N_WIRES);
            if (!grant.found && eligible[idx[ID_W-1:0]]) begin
                grant.found = 1'b1;
                grant.id    = idx[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant.found) state_d = S_OFFER;
            S_OFFER: if (irq_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        irq_valid_o = (state_q == S_OFFER);
        irq_id_o    = id_q;
    end

    // id is captured only on a new grant, so it holds while offered regardless of enable_i
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_q   <= '0;
            rr_ptr <= '0;
        end else begin
            if (state_q == S_IDLE && grant.found)
                id_q <= grant.id;
            if (handshake)
                rr_ptr <= (id_q == ID_W'(N_WIRES-1)) ? '0 : id_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_iommu_wsi_gateway.sv
// Bench for iommu_wsi_gateway: directed scenarios plus randomized traffic against a cycle model.
module tb_iommu_wsi_gateway;
    localparam int N = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  wires, en;
    logic          ready, cv;
    logic [3:0]    cid;
    logic          valid;
    logic [3:0]    id;
    logic [N-1:0]  pend, svc;

    int checks = 0;
    int errors = 0;

    iommu_wsi_gateway #(.N_WIRES(N)) dut (
        .clk_i(clk), .rst_i(rst), .wsi_wires_i(wires), .enable_i(en),
        .irq_valid_o(valid), .irq_id_o(id), .irq_ready_i(ready),
        .complete_valid_i(cv), .complete_id_i(cid),
        .pending_o(pend), .in_service_o(svc)
    );

    always #5 clk = ~clk;

    // Reference model built straight from the gateway rules
    logic [N-1:0] m_pend, m_svc;
    logic         m_valid;
    int           m_id, m_rr;

    always @(posedge clk) begin : model_b
        logic [N-1:0] np, ns;
        logic found;
        int j;
        if (rst) begin
            m_pend <= '0; m_svc <= '0; m_valid <= 1'b0; m_id <= 0; m_rr <= 0;
        end else begin
            np = m_pend; ns = m_svc;
            if (cv && int'(cid) < N && m_svc[cid]) ns[cid] = 1'b0;
            for (int i = 0; i < N; i++)
                if (wires[i] && !m_pend[i] && !m_svc[i]) np[i] = 1'b1;
            if (m_valid && ready) begin
                np[m_id] = 1'b0;
                ns[m_id] = 1'b1;
                m_valid <= 1'b0;
                m_rr    <= (m_id + 1) % N;
            end else if (!m_valid) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    j = (m_rr + k) % N;
                    if (!found && m_pend[j] && en[j]) begin
                        found = 1'b1;
                        m_valid <= 1'b1;
                        m_id    <= j;
                    end
                end
            end
            m_pend <= np; m_svc <= ns;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; wires = '0; en = '1; ready = 1'b0; cv = 1'b0; cid = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pend !== 16'h0) begin errors++; $display("FAIL reset_pending got %h exp 0000", pend); end
        checks++; if (svc !== 16'h0) begin errors++; $display("FAIL reset_in_service got %h exp 0000", svc); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
        checks++; if (id !== 4'd0) begin errors++; $display("FAIL reset_id got %0d exp 0", id); end
    endtask

    task automatic test_latency();
        wires = 16'h0008;
        tick();
        checks++; if (pend !== 16'h0008) begin errors++; $display("FAIL lat_pending got %h exp 0008", pend); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL lat_valid_early got %b exp 0", valid); end
        tick();
        checks++; if (valid !== 1'b1 || id !== 4'd3) begin errors++; $display("FAIL lat_valid got v=%b id=%0d exp v=1 id=3", valid, id); end
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++; if (valid !== 1'b1 || id !== 4'd3) begin errors++; $display("FAIL lat_hold cyc %0d got v=%b id=%0d exp v=1 id=3", c, valid, id); end
        end
    endtask

    task automatic test_claim_complete();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checks++; if (pend !== 16'h0 || svc !== 16'h0008 || valid !== 1'b0) begin errors++;
            $display("FAIL claim got pend=%h svc=%h v=%b exp 0000 0008 0", pend, svc, valid); end
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL claim_no_revalid got %b exp 0", valid); end
        cv = 1'b1; cid = 4'd3;
        tick();
        cv = 1'b0;
        checks++; if (svc !== 16'h0 || pend !== 16'h0) begin errors++; $display("FAIL complete got svc=%h pend=%h exp 0000 0000", svc, pend); end
        tick();
        checks++; if (pend !== 16'h0008) begin errors++; $display("FAIL rearm_pending got %h exp 0008", pend); end
        tick();
        checks++; if (valid !== 1'b1 || id !== 4'd3) begin errors++; $display("FAIL rearm_valid got v=%b id=%0d exp v=1 id=3", valid, id); end
    endtask

    task automatic test_round_robin();
        int grants[$];
        int gcyc[$];
        int exp_ids[4] = '{1, 2, 5, 1};
        logic cpl_pend;
        logic [3:0] cpl_id;
        do_reset();
        wires = 16'h0026; ready = 1'b1; cpl_pend = 1'b0; cpl_id = '0;
        for (int c = 0; c < 40 && grants.size() < 4; c++) begin
            cv = 1'b0;
            if (cpl_pend) begin cv = 1'b1; cid = cpl_id; cpl_pend = 1'b0; end
            if (valid) begin grants.push_back(int'(id)); gcyc.push_back(c); cpl_pend = 1'b1; cpl_id = id; end
            tick();
        end
        cv = 1'b0; ready = 1'b0;
        checks++;
        if (grants.size() != 4) begin errors++; $display("FAIL rr_count got %0d exp 4", grants.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (grants[i] != exp_ids[i]) begin errors++; $display("FAIL rr_order[%0d] got %0d exp %0d", i, grants[i], exp_ids[i]); end
            end
            for (int i = 1; i < 4; i++) begin
                checks++; if (gcyc[i] - gcyc[i-1] != 2) begin errors++; $display("FAIL rr_spacing[%0d] got %0d exp 2", i, gcyc[i] - gcyc[i-1]); end
            end
        end
    endtask

    task automatic test_masking();
        do_reset();
        en = ~16'h0080; wires = 16'h0080;
        tick();
        checks++; if (pend !== 16'h0080) begin errors++; $display("FAIL mask_pending got %h exp 0080", pend); end
        tick(); tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mask_valid got %b exp 0", valid); end
        en = '1;
        tick();
        checks++; if (valid !== 1'b1 || id !== 4'd7) begin errors++; $display("FAIL unmask got v=%b id=%0d exp v=1 id=7", valid, id); end
        en = ~16'h0080;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (valid !== 1'b1 || id !== 4'd7) begin errors++; $display("FAIL mask_hold got v=%b id=%0d exp v=1 id=7", valid, id); end
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checks++; if (valid !== 1'b0 || svc !== 16'h0080) begin errors++; $display("FAIL mask_claim got v=%b svc=%h exp 0 0080", valid, svc); end
    endtask

    task automatic test_illegal_completions();
        do_reset();
        wires = 16'h0008;
        tick(); tick();
        ready = 1'b1;
        tick();
        ready = 1'b0; cv = 1'b1; cid = 4'd4;
        tick();
        cv = 1'b0;
        checks++; if (svc !== 16'h0008 || pend !== 16'h0) begin errors++; $display("FAIL bad_cpl got svc=%h pend=%h exp 0008 0000", svc, pend); end
        cv = 1'b1; cid = 4'd3;
        tick();
        cv = 1'b0;
        tick(); tick();
        checks++; if (valid !== 1'b1 || id !== 4'd3) begin errors++; $display("FAIL reoffer got v=%b id=%0d exp v=1 id=3", valid, id); end
        ready = 1'b1; cv = 1'b1; cid = 4'd3;
        tick();
        ready = 1'b0; cv = 1'b0;
        checks++; if (svc !== 16'h0008 || pend !== 16'h0 || valid !== 1'b0) begin errors++;
            $display("FAIL same_cyc got svc=%h pend=%h v=%b exp 0008 0000 0", svc, pend, valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        wires = 16'h0001;
        tick(); tick();
        ready = 1'b1;
        tick();
        ready = 1'b0; wires = 16'h0601;
        tick(); tick();
        checks++; if (valid !== 1'b1 || id !== 4'd9 || pend !== 16'h0600 || svc !== 16'h0001) begin errors++;
            $display("FAIL mid_setup got v=%b id=%0d pend=%h svc=%h exp 1 9 0600 0001", valid, id, pend, svc); end
        rst = 1'b1;
        tick();
        rst = 1'b0; wires = 16'h0600;
        checks++; if (valid !== 1'b0 || id !== 4'd0 || pend !== 16'h0 || svc !== 16'h0) begin errors++;
            $display("FAIL mid_reset got v=%b id=%0d pend=%h svc=%h exp all 0", valid, id, pend, svc); end
        tick();
        checks++; if (pend !== 16'h0600 || valid !== 1'b0) begin errors++; $display("FAIL mid_relatch got pend=%h v=%b exp 0600 0", pend, valid); end
        tick();
        checks++; if (valid !== 1'b1 || id !== 4'd9) begin errors++; $display("FAIL mid_regrant got v=%b id=%0d exp v=1 id=9", valid, id); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            checks++; if (valid !== m_valid) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", c, valid, m_valid); end
            checks++; if (pend !== m_pend) begin errors++; $display("FAIL rnd_pending cyc %0d got %h exp %h", c, pend, m_pend); end
            checks++; if (svc !== m_svc) begin errors++; $display("FAIL rnd_in_service cyc %0d got %h exp %h", c, svc, m_svc); end
            if (m_valid) begin
                checks++; if (int'(id) != m_id) begin errors++; $display("FAIL rnd_id cyc %0d got %0d exp %0d", c, id, m_id); end
            end
            rst   = ($urandom_range(0, 299) == 0);
            wires = wires ^ N'($urandom & $urandom & $urandom);
            en    = ~N'($urandom & $urandom & $urandom & $urandom);
            ready = ($urandom_range(0, 2) != 0);
            cv    = ($urandom_range(0, 1) != 0);
            cid   = 4'($urandom_range(0, N-1));
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wires = '0; en = '1; ready = 1'b0; cv = 1'b0; cid = '0;
        @(negedge clk);
        test_reset();
        test_latency();
        test_claim_complete();
        test_round_robin();
        test_masking();
        test_illegal_completions();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
